cc_frame_joiner: RTL and testbench

//  Parametrised successor of the 8x8 car/environment joiner for the LED-matrix display path.

---
 rtl/cc_frame_joiner_pkg.sv | 18 +
 rtl/cc_frame_joiner_if.sv | 43 ++++
 rtl/cc_frame_joiner_row_merge.sv | 34 +++
 rtl/cc_frame_joiner.sv | 144 ++++++++++++++
 tb/tb_cc_frame_joiner.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cc_frame_joiner_pkg.sv
// cc_frame_joiner_pkg
//   Shared types and constants for the car/environment frame joiner.
//   state_t  : RUN/CRASH game state, also exported on the debug state port.
//   MODE_*   : merge mode encoding on mode_in.
//   CNT_MAX  : saturation value of the collision counter.
package cc_frame_joiner_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CRASH = 1'b1
  } state_t;

  localparam logic MODE_XOR = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  localparam logic [7:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/cc_frame_joiner_if.sv
// cc_frame_joiner_if
//   Bundles the frame input, the registered frame output and the game-control
//   signals of cc_frame_joiner.
//   master : the producer/consumer/controller side (testbench or game logic).
//   slave  : the joiner itself.
//   Signals: env_frame_in, car_bus_in, car_row_in, mode_in, valid_in, ready_out,
//            frame_out, valid_out, ready_in, crash_out, crash_clear_in,
//            crash_count_out, state (debug view of the RUN/CRASH FSM).
interface cc_frame_joiner_if
  import cc_frame_joiner_pkg::*;
#(
  parameter int COLS  = 8,
  parameter int ROWS  = 8,
  parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
);

  logic [ROWS*COLS-1:0] env_frame_in;
  logic [COLS-1:0]      car_bus_in;
  logic [ROW_W-1:0]     car_row_in;
  logic                 mode_in;
  logic                 valid_in;
  logic                 ready_out;
  logic [ROWS*COLS-1:0] frame_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 crash_out;
  logic                 crash_clear_in;
  logic [7:0]           crash_count_out;
  state_t               state;

  modport master (
    output env_frame_in, car_bus_in, car_row_in, mode_in, valid_in,
    output ready_in, crash_clear_in,
    input  ready_out, frame_out, valid_out, crash_out, crash_count_out, state
  );

  modport slave (
    input  env_frame_in, car_bus_in, car_row_in, mode_in, valid_in,
    input  ready_in, crash_clear_in,
    output ready_out, frame_out, valid_out, crash_out, crash_count_out, state
  );

endinterface

// File: rtl/cc_frame_joiner_row_merge.sv
// cc_frame_joiner_row_merge
//   Combinational merge of the car sprite into one environment row.
//   env_row    : environment row bits
//   car_row    : car sprite bits
//   sel        : this row is the car's target row
//   show       : car is visible (low during a hidden blink phase)
//   mode       : MODE_XOR / MODE_OR
//   merged_row : row to register into the output frame
//   hit        : car overlaps environment on this row (independent of show)
module cc_frame_joiner_row_merge
  import cc_frame_joiner_pkg::*;
#(
  parameter int COLS = 8
) (
  input  logic [COLS-1:0] env_row,
  input  logic [COLS-1:0] car_row,
  input  logic            sel,
  input  logic            show,
  input  logic            mode,
  output logic [COLS-1:0] merged_row,
  output logic            hit
);

  always_comb begin
    merged_row = env_row;
    if (sel && show) begin
      merged_row = (mode == MODE_OR) ? (env_row | car_row) : (env_row ^ car_row);
    end
  end

  // A hidden car still collides: blinking is purely cosmetic.
  assign hit = sel && (|(env_row & car_row));

endmodule

// File: rtl/cc_frame_joiner.sv
// cc_frame_joiner
//   Merges a car sprite row into a ROWSxCOLS environment frame, registers the
//   result behind a one-deep valid/ready output stage, counts collisions and
//   runs the RUN/CRASH game FSM.
//   Ports:
//     CC_FRAME_JOINER_CLOCK_50    : clock, rising edge
//     CC_FRAME_JOINER_RESET_InLow : synchronous active-low reset
//     bus (cc_frame_joiner_if.slave) : frame in/out handshake, crash control,
//                                      collision counter, debug state
//   Configuration macro: CC_FRAME_JOINER_BLINK_EN
//     defined   : in CRASH the car alternates shown/hidden every BLINK_FRAMES
//                 accepted frames, starting shown on CRASH entry.
//     undefined : car always shown, no blink logic built.
module cc_frame_joiner
  import cc_frame_joiner_pkg::*;
#(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int BLINK_FRAMES = 4
) (
  input logic               CC_FRAME_JOINER_CLOCK_50,
  input logic               CC_FRAME_JOINER_RESET_InLow,
  cc_frame_joiner_if.slave  bus
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                 clk;
  logic                 rst_n;
  logic                 accept;
  logic                 accept_hit;
  logic                 show_car;
  logic [ROWS-1:0]      hits;
  logic [ROWS*COLS-1:0] merged;
  logic [ROWS*COLS-1:0] frame_q;
  logic                 valid_q;
  logic [7:0]           count_q;
  state_t               state;
  state_t               state_next;

  assign clk   = CC_FRAME_JOINER_CLOCK_50;
  assign rst_n = CC_FRAME_JOINER_RESET_InLow;

  // Handshake: a transfer happens on a clock edge where valid and ready are
  // both high. The output stage is one deep, so the joiner is ready whenever
  // the stage is empty or is being drained in the same cycle.
  assign bus.ready_out = !valid_q || bus.ready_in;
  assign accept        = bus.valid_in && bus.ready_out;
  assign accept_hit    = accept && (|hits);

  // Rows are matched by equality only, so an out-of-range car_row_in selects
  // no row: the frame passes through and no hit is possible.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    cc_frame_joiner_row_merge #(.COLS(COLS)) u_merge (
      .env_row    (bus.env_frame_in[r*COLS +: COLS]),
      .car_row    (bus.car_bus_in),
      .sel        (bus.car_row_in == ROW_W'(r)),
      .show       (show_car),
      .mode       (bus.mode_in),
      .merged_row (merged[r*COLS +: COLS]),
      .hit        (hits[r])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      frame_q <= merged;
      valid_q <= 1'b1;
    end else if (bus.ready_in) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (accept_hit && (count_q != CNT_MAX)) begin
      count_q <= count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A hit accepted in the same cycle as a clear keeps the game in CRASH.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept_hit) state_next = CRASH;
      CRASH:   if (!accept_hit && bus.crash_clear_in) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

`ifdef CC_FRAME_JOINER_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_hide;

  // Counts accepted frames while in CRASH; the frame that causes the entry is
  // itself merged under RUN rules and does not count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt  <= '0;
      blink_hide <= 1'b0;
    end else if ((state == RUN) && (state_next == CRASH)) begin
      blink_cnt  <= '0;
      blink_hide <= 1'b0;
    end else if ((state == CRASH) && accept) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt  <= '0;
        blink_hide <= !blink_hide;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign show_car = !((state == CRASH) && blink_hide);
`else
  // BLINK_FRAMES only matters when blinking is built in.
  logic unused_blink_frames;
  assign unused_blink_frames = ^BLINK_FRAMES;
  assign show_car = 1'b1;
`endif

  assign bus.frame_out       = frame_q;
  assign bus.valid_out       = valid_q;
  assign bus.crash_count_out = count_q;
  // State and frame register update on the same edge, so CRASH shows up
  // together with the colliding frame.
  assign bus.crash_out       = (state == CRASH);
  assign bus.state           = state;

endmodule

// File: tb/tb_cc_frame_joiner.sv
module tb_cc_frame_joiner;
  import cc_frame_joiner_pkg::*;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  logic [63:0] exp_q[$];

  cc_frame_joiner_if #(.COLS(8), .ROWS(8)) bus ();

  cc_frame_joiner #(.COLS(8), .ROWS(8), .BLINK_FRAMES(4)) dut (
    .CC_FRAME_JOINER_CLOCK_50    (clk),
    .CC_FRAME_JOINER_RESET_InLow (rst_n),
    .bus                         (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [63:0] env, input logic [7:0] car,
                           input logic [2:0] row, input logic mode);
    bus.env_frame_in = env;
    bus.car_bus_in   = car;
    bus.car_row_in   = row;
    bus.mode_in      = mode;
  endtask

  // One-cycle frame offer; caller keeps ready_in high so it is accepted.
  task automatic send(input logic [63:0] env, input logic [7:0] car,
                      input logic [2:0] row, input logic mode);
    set_frame(env, car, row, mode);
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] frame_b;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    bus.crash_clear_in = 1'b0;
    bus.ready_in       = 1'b1;
    bus.valid_in       = 1'b0;
    set_frame(64'h0, 8'h0, 3'd0, MODE_XOR);

    // 1. reset with valid_in high
    rst_n = 1'b0;
    set_frame(64'hDEAD_BEEF_0123_4567, 8'hFF, 3'd2, MODE_OR);
    bus.valid_in = 1'b1;
    tick();
    tick();
    check("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check("rst_frame_out", bus.frame_out, 64'd0);
    check("rst_count", 64'(bus.crash_count_out), 64'd0);
    check("rst_ready_out", 64'(bus.ready_out), 64'd1);
    check("rst_crash", 64'(bus.crash_out), 64'd0);
    check("rst_state", 64'(bus.state), 64'(RUN));
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
    tick();

    // 2. empty environment, car on row 0
    send(64'h0, 8'h18, 3'd0, MODE_XOR);
    check("row0_frame", bus.frame_out, 64'h0000_0000_0000_0018);
    check("row0_valid", 64'(bus.valid_out), 64'd1);
    check("row0_crash", 64'(bus.crash_out), 64'd0);
    tick();
    check("drain_valid", 64'(bus.valid_out), 64'd0);

    // clear request in RUN is ignored
    bus.crash_clear_in = 1'b1;
    tick();
    bus.crash_clear_in = 1'b0;
    check("clear_in_run", 64'(bus.state), 64'(RUN));

    // 3. collision on row 3, XOR then OR
    send(64'h0000_0000_1000_0000, 8'h18, 3'd3, MODE_XOR);
    check("xor_frame", bus.frame_out, 64'h0000_0000_0800_0000);
    check("xor_crash", 64'(bus.crash_out), 64'd1);
    check("xor_count", 64'(bus.crash_count_out), 64'd1);
    send(64'h0000_0000_1000_0000, 8'h18, 3'd3, MODE_OR);
    check("or_frame", bus.frame_out, 64'h0000_0000_1800_0000);
    check("or_count", 64'(bus.crash_count_out), 64'd2);
    bus.crash_clear_in = 1'b1;
    tick();
    bus.crash_clear_in = 1'b0;
    check("clear_crash", 64'(bus.crash_out), 64'd0);
    check("clear_count", 64'(bus.crash_count_out), 64'd2);
    check("clear_valid", 64'(bus.valid_out), 64'd0);

    // 4. backpressure: frame A held while a different frame B waits
    bus.ready_in = 1'b0;
    send(64'h0123_4567_89AB_CDEF, 8'h00, 3'd5, MODE_XOR);
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    set_frame(64'h0, 8'h0F, 3'd1, MODE_OR);
    frame_b = 64'h0000_0000_0000_0F00;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_ready_%0d", i), 64'(bus.ready_out), 64'd0);
      check($sformatf("stall_frame_%0d", i), bus.frame_out, exp_q[0]);
      tick();
    end
    bus.ready_in = 1'b1;
    #1;
    check("release_ready", 64'(bus.ready_out), 64'd1);
    exp_q.push_back(frame_b);
    tick();
    void'(exp_q.pop_front());
    bus.valid_in = 1'b0;
    check("frame_b", bus.frame_out, exp_q[0]);
    check("frame_b_valid", 64'(bus.valid_out), 64'd1);
    check("frame_b_state", 64'(bus.state), 64'(RUN));
    tick();
    void'(exp_q.pop_front());
    check("frame_b_drain", 64'(bus.valid_out), 64'd0);

    // 5. clear together with a hit, then saturation
    send(64'h0000_0000_0000_00FF, 8'h01, 3'd0, MODE_XOR);
    check("hit3_frame", bus.frame_out, 64'h0000_0000_0000_00FE);
    check("hit3_count", 64'(bus.crash_count_out), 64'd3);
    bus.crash_clear_in = 1'b1;
    send(64'h0000_0000_0000_00FF, 8'h01, 3'd0, MODE_XOR);
    bus.crash_clear_in = 1'b0;
    check("clear_hit_state", 64'(bus.state), 64'(CRASH));
    check("clear_hit_count", 64'(bus.crash_count_out), 64'd4);
    set_frame(64'h00FF_0000_0000_0000, 8'h81, 3'd6, MODE_OR);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    bus.valid_in = 1'b0;
    check("sat_count", 64'(bus.crash_count_out), 64'd255);
    check("sat_frame", bus.frame_out, 64'h00FF_0000_0000_0000);
    check("sat_crash", 64'(bus.crash_out), 64'd1);
    bus.crash_clear_in = 1'b1;
    tick();
    bus.crash_clear_in = 1'b0;
    check("sat_clear_state", 64'(bus.state), 64'(RUN));
    check("sat_hold_count", 64'(bus.crash_count_out), 64'd255);

    // 6. car visibility during CRASH (blinks only when built in)
    send(64'h0000_0000_0000_0100, 8'h01, 3'd1, MODE_XOR);
    check("blink_entry", 64'(bus.state), 64'(CRASH));
    for (int i = 1; i <= 8; i++) begin
      send(64'h0, 8'h3C, 3'd2, MODE_XOR);
`ifdef CC_FRAME_JOINER_BLINK_EN
      check($sformatf("crash_frame_%0d", i), bus.frame_out,
            (i <= 4) ? 64'h0000_0000_003C_0000 : 64'h0);
`else
      check($sformatf("crash_frame_%0d", i), bus.frame_out, 64'h0000_0000_003C_0000);
`endif
    end
    bus.crash_clear_in = 1'b1;
    tick();
    bus.crash_clear_in = 1'b0;
    check("blink_clear", 64'(bus.state), 64'(RUN));
    for (int i = 0; i < 2; i++) begin
      send(64'h0, 8'h3C, 3'd2, MODE_XOR);
      check($sformatf("run_frame_%0d", i), bus.frame_out, 64'h0000_0000_003C_0000);
    end

    // reset while a frame is stalled at the output
    bus.ready_in = 1'b0;
    send(64'hFFFF_0000_FFFF_0000, 8'h0F, 3'd7, MODE_OR);
    check("stall_before_rst", 64'(bus.valid_out), 64'd1);
    rst_n = 1'b0;
    bus.valid_in = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    check("mid_rst_valid", 64'(bus.valid_out), 64'd0);
    check("mid_rst_frame", bus.frame_out, 64'd0);
    check("mid_rst_count", 64'(bus.crash_count_out), 64'd0);
    check("mid_rst_crash", 64'(bus.crash_out), 64'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
